// File: rtl/audio_wr_burst_ctrl.sv
// Recording-side burst writer: buffers the 64-bit sample stream in a FIFO and
// writes fixed-length bursts to memory. Optional build macro: AUDIO_WR_OVF_CNT_EN (ovf_cnt counter).
module audio_wr_burst_ctrl #(
  parameter int unsigned MEM_ADDR_W = 24,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned FIFO_DEPTH = 128,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned MAX_WORDS  = 24'h100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_req,
  output logic                  write_req_ack,
  input  logic                  write_en,
  input  logic [63:0]           write_data,
  output logic                  mem_wr_burst_req,
  output logic [9:0]            mem_wr_burst_len,
  output logic [MEM_ADDR_W-1:0] mem_wr_burst_addr,
  input  logic                  mem_wr_burst_data_req,
  output logic [63:0]           mem_wr_burst_data,
  input  logic                  mem_wr_burst_finish,
  output logic [MEM_ADDR_W-1:0] words_written,
  output logic                  overflow,
  output logic                  mem_full,
  output logic [15:0]           ovf_cnt
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [MEM_ADDR_W-1:0] END_ADDR = MEM_ADDR_W'(BASE_ADDR + MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RECORD,
    BURST,
    DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [63:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [LW-1:0]         r_level;
  logic [63:0]           r_rd_data;

  logic [MEM_ADDR_W-1:0] r_addr;
  logic [MEM_ADDR_W-1:0] r_words;
  logic                  r_overflow;
  logic                  r_mem_full;

  logic                  w_accepting;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_burst_done;
  logic [MEM_ADDR_W-1:0] w_addr_next;
  logic                  w_region_end;

  // Samples are only taken while a session is live; a pop on a full FIFO frees
  // the slot the same cycle, so the concurrent push is not dropped.
  assign w_accepting  = (r_state == RECORD) || (r_state == BURST);
  assign w_full       = (r_level == LW'(FIFO_DEPTH));
  assign w_pop        = (r_state == BURST) && mem_wr_burst_data_req && (r_level != '0);
  assign w_push       = w_accepting && write_en && (!w_full || w_pop);
  assign w_drop       = w_accepting && write_en && w_full && !w_pop;
  assign w_burst_done = (r_state == BURST) && mem_wr_burst_finish;
  assign w_addr_next  = r_addr + MEM_ADDR_W'(BURST_LEN);
  assign w_region_end = (w_addr_next == END_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (write_req) w_next = ACK;
      ACK:    w_next = RECORD;
      RECORD: begin
        if (write_req) begin
          w_next = ACK;
        end else if ((r_level >= LW'(BURST_LEN)) && !r_mem_full) begin
          w_next = BURST;
        end
      end
      BURST: begin
        if (mem_wr_burst_finish) begin
          if (w_region_end)   w_next = DONE;
          else if (write_req) w_next = ACK;
          else                w_next = RECORD;
        end
      end
      DONE:   if (write_req) w_next = ACK;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (r_state == ACK) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Pops of an empty FIFO leave the output register holding the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_pop) begin
      r_rd_data <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_words    <= '0;
      r_overflow <= 1'b0;
      r_mem_full <= 1'b0;
    end else if (r_state == ACK) begin
      r_addr     <= MEM_ADDR_W'(BASE_ADDR);
      r_words    <= '0;
      r_overflow <= 1'b0;
      r_mem_full <= 1'b0;
    end else begin
      if (w_burst_done) begin
        r_addr  <= w_addr_next;
        r_words <= r_words + MEM_ADDR_W'(BURST_LEN);
        if (w_region_end) r_mem_full <= 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef AUDIO_WR_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (r_state == ACK) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`else
  assign ovf_cnt = '0;
`endif

  assign write_req_ack     = (r_state == ACK);
  assign mem_wr_burst_req  = (r_state == BURST);
  assign mem_wr_burst_len  = (r_state == BURST) ? 10'(BURST_LEN) : '0;
  assign mem_wr_burst_addr = r_addr;
  assign mem_wr_burst_data = r_rd_data;
  assign words_written     = r_words;
  assign overflow          = r_overflow;
  assign mem_full          = r_mem_full;

endmodule

// File: tb/tb_audio_wr_burst_ctrl.sv
// Directed bench for audio_wr_burst_ctrl: session-start vector table plus
// hand-written burst, overflow, region-full, mid-burst request and reset sequences.
module tb_audio_wr_burst_ctrl;

  localparam int unsigned BASE = 256;
`ifdef AUDIO_WR_OVF_CNT_EN
  localparam logic [15:0] EXP_OVF = 16'd72;
`else
  localparam logic [15:0] EXP_OVF = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        write_req;
  logic        write_req_ack;
  logic        write_en;
  logic [63:0] write_data;
  logic        mem_wr_burst_req;
  logic [9:0]  mem_wr_burst_len;
  logic [23:0] mem_wr_burst_addr;
  logic        mem_wr_burst_data_req;
  logic [63:0] mem_wr_burst_data;
  logic        mem_wr_burst_finish;
  logic [23:0] words_written;
  logic        overflow;
  logic        mem_full;
  logic [15:0] ovf_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  audio_wr_burst_ctrl #(
    .MEM_ADDR_W(24),
    .BURST_LEN (64),
    .FIFO_DEPTH(128),
    .BASE_ADDR (BASE),
    .MAX_WORDS (128)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .write_req            (write_req),
    .write_req_ack        (write_req_ack),
    .write_en             (write_en),
    .write_data           (write_data),
    .mem_wr_burst_req     (mem_wr_burst_req),
    .mem_wr_burst_len     (mem_wr_burst_len),
    .mem_wr_burst_addr    (mem_wr_burst_addr),
    .mem_wr_burst_data_req(mem_wr_burst_data_req),
    .mem_wr_burst_data    (mem_wr_burst_data),
    .mem_wr_burst_finish  (mem_wr_burst_finish),
    .words_written        (words_written),
    .overflow             (overflow),
    .mem_full             (mem_full),
    .ovf_cnt              (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        en;
    logic [63:0] data;
    logic        exp_ack;
    logic        exp_breq;
    logic [23:0] exp_words;
    logic        exp_full;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic feed(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      write_en   = 1'b1;
      write_data = base + 64'(i);
      @(negedge clk);
    end
    write_en = 1'b0;
  endtask

  task automatic wait_breq(output bit ok);
    int cnt = 0;
    while (!mem_wr_burst_req && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    ok = mem_wr_burst_req;
  endtask

  task automatic start_session();
    int cnt = 0;
    write_req = 1'b1;
    @(negedge clk);
    while (!write_req_ack && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("ack_seen", 64'(write_req_ack), 64'd1);
    write_req = 1'b0;
    @(negedge clk);
    chk("ack_single_pulse", 64'(write_req_ack), 64'd0);
  endtask

  // Memory model: waits for a request, optionally stalls, pulls npops words,
  // checks each returned word, then pulses finish.
  task automatic mem_burst(input logic [23:0] exp_addr, input int stall,
                           input logic [63:0] first, input int npops, input int req_at);
    bit ok;
    wait_breq(ok);
    chk("burst_req_timeout", 64'(ok), 64'd1);
    if (ok) begin
      chk("burst_addr", 64'(mem_wr_burst_addr), 64'(exp_addr));
      chk("burst_len", 64'(mem_wr_burst_len), 64'd64);
      repeat (stall) @(negedge clk);
      for (int i = 0; i < npops; i++) begin
        mem_wr_burst_data_req = 1'b1;
        if (i == req_at) write_req = 1'b1;
        @(negedge clk);
        chk("burst_data", mem_wr_burst_data, first + 64'((i > 63) ? 63 : i));
        if (req_at >= 0) chk("ack_withheld", 64'(write_req_ack), 64'd0);
      end
      mem_wr_burst_data_req = 1'b0;
      chk("req_stable_addr", 64'(mem_wr_burst_addr), 64'(exp_addr));
      mem_wr_burst_finish = 1'b1;
      @(negedge clk);
      mem_wr_burst_finish = 1'b0;
      chk("req_dropped_after_finish", 64'(mem_wr_burst_req), 64'd0);
    end
  endtask

  initial begin
    bit ok;
    bit seen;

    vecs[0] = '{req: 1'b0, en: 1'b1, data: 64'hDEAD, exp_ack: 1'b0, exp_breq: 1'b0, exp_words: 24'd0, exp_full: 1'b0};
    vecs[1] = '{req: 1'b1, en: 1'b0, data: 64'h0,    exp_ack: 1'b1, exp_breq: 1'b0, exp_words: 24'd0, exp_full: 1'b0};
    vecs[2] = '{req: 1'b0, en: 1'b0, data: 64'h0,    exp_ack: 1'b0, exp_breq: 1'b0, exp_words: 24'd0, exp_full: 1'b0};
    vecs[3] = '{req: 1'b0, en: 1'b0, data: 64'h0,    exp_ack: 1'b0, exp_breq: 1'b0, exp_words: 24'd0, exp_full: 1'b0};

    rst = 1'b1;
    write_req = 1'b0;
    write_en = 1'b0;
    write_data = '0;
    mem_wr_burst_data_req = 1'b0;
    mem_wr_burst_finish = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 64'(write_req_ack), 64'd0);
    chk("rst_breq", 64'(mem_wr_burst_req), 64'd0);
    chk("rst_len", 64'(mem_wr_burst_len), 64'd0);
    chk("rst_addr", 64'(mem_wr_burst_addr), 64'd0);
    chk("rst_words", 64'(words_written), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Session start; the IDLE-cycle sample must not reach the FIFO.
    for (int i = 0; i < 4; i++) begin
      write_req  = vecs[i].req;
      write_en   = vecs[i].en;
      write_data = vecs[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d_ack", i), 64'(write_req_ack), 64'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_breq", i), 64'(mem_wr_burst_req), 64'(vecs[i].exp_breq));
      chk($sformatf("vec%0d_words", i), 64'(words_written), 64'(vecs[i].exp_words));
      chk($sformatf("vec%0d_full", i), 64'(mem_full), 64'(vecs[i].exp_full));
    end
    write_req = 1'b0;
    write_en  = 1'b0;

    // First burst: words 0..63, request one cycle after level reaches 64.
    feed(64, 64'd0);
    chk("breq_not_yet", 64'(mem_wr_burst_req), 64'd0);
    @(negedge clk);
    chk("breq_rise", 64'(mem_wr_burst_req), 64'd1);
    mem_burst(24'(BASE), 0, 64'd0, 64, -1);
    chk("words_64", 64'(words_written), 64'd64);
    chk("no_ovf_yet", 64'(overflow), 64'd0);

    // Overflow under a stalled memory, second burst fills the region.
    fork
      feed(200, 64'd1000);
      mem_burst(24'(BASE + 64), 300, 64'd1000, 64, -1);
    join
    chk("overflow_set", 64'(overflow), 64'd1);
    chk("ovf_cnt_72", 64'(ovf_cnt), 64'(EXP_OVF));
    chk("mem_full_set", 64'(mem_full), 64'd1);
    chk("words_128", 64'(words_written), 64'd128);

    // DONE: leftover FIFO words must not start a third burst; drops not counted.
    seen = 1'b0;
    feed(10, 64'd9000);
    for (int i = 0; i < 20; i++) begin
      if (mem_wr_burst_req) seen = 1'b1;
      @(negedge clk);
    end
    chk("no_third_req", 64'(seen), 64'd0);
    chk("done_ovf_cnt_hold", 64'(ovf_cnt), 64'(EXP_OVF));

    start_session();
    chk("new_words_clr", 64'(words_written), 64'd0);
    chk("new_ovf_clr", 64'(overflow), 64'd0);
    chk("new_full_clr", 64'(mem_full), 64'd0);
    chk("new_cnt_clr", 64'(ovf_cnt), 64'd0);

    // write_req raised mid-burst: ack only after finish.
    fork
      feed(64, 64'd2000);
      mem_burst(24'(BASE), 0, 64'd2000, 64, 10);
    join
    chk("ack_after_finish", 64'(write_req_ack), 64'd1);
    chk("words_at_ack", 64'(words_written), 64'd64);
    write_req = 1'b0;
    @(negedge clk);
    chk("ack_pulse_end", 64'(write_req_ack), 64'd0);
    chk("words_cleared", 64'(words_written), 64'd0);

    // Partial fill discarded by a new session; also one extra data_req pop.
    feed(40, 64'hBAD0);
    start_session();
    fork
      feed(64, 64'd3000);
      mem_burst(24'(BASE), 0, 64'd3000, 65, -1);
    join
    chk("words_after_flush", 64'(words_written), 64'd64);

    // Asynchronous reset in the middle of a burst.
    feed(64, 64'd4000);
    wait_breq(ok);
    chk("rst_test_breq", 64'(ok), 64'd1);
    mem_wr_burst_data_req = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_breq", 64'(mem_wr_burst_req), 64'd0);
    chk("arst_ack", 64'(write_req_ack), 64'd0);
    chk("arst_len", 64'(mem_wr_burst_len), 64'd0);
    chk("arst_addr", 64'(mem_wr_burst_addr), 64'd0);
    chk("arst_data", mem_wr_burst_data, 64'd0);
    chk("arst_words", 64'(words_written), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_full", 64'(mem_full), 64'd0);
    chk("arst_cnt", 64'(ovf_cnt), 64'd0);
    mem_wr_burst_data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_session();
    feed(63, 64'd5000);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mem_wr_burst_req) seen = 1'b1;
      @(negedge clk);
    end
    chk("fifo_empty_after_rst", 64'(seen), 64'd0);
    feed(1, 64'd5063);
    mem_burst(24'(BASE), 0, 64'd5000, 64, -1);
    chk("words_after_rst", 64'(words_written), 64'd64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
